// File: rtl/dense_mac_relu.sv
// dense_mac_relu: dense layer N_IN -> N_OUT with ReLU and saturation.
// N_OUT parallel MACs walk the input vector one element per cycle while a
// synchronous weight ROM delivers one row (all N_OUT weights) per cycle.
// All DATA_W quantities are signed fixed point with FRAC_W fractional bits.
module dense_mac_relu #(
   parameter int DATA_W = 16,
   parameter int FRAC_W = 10,
   parameter int N_IN   = 128,
   parameter int N_OUT  = 16
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic signed [DATA_W-1:0]   in_data [N_IN],
   output logic [$clog2(N_IN)-1:0]    w_addr,
   input  logic [N_OUT*DATA_W-1:0]    w_data,
   input  logic signed [DATA_W-1:0]   bias [N_OUT],
   output logic                       out_valid,
   output logic signed [DATA_W-1:0]   out_data [N_OUT]
);

   localparam int AW     = $clog2(N_IN);
   localparam int CNT_W  = AW + 1;
   localparam int PROD_W = 2 * DATA_W;
   // Wide enough that N_IN full-scale products can never overflow.
   localparam int ACC_W  = 2 * DATA_W + AW + 1;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N_IN);
   localparam logic [CNT_W-1:0] CNT_ADDR_LAST = CNT_W'(N_IN - 1);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACC    = 2'd1,
      ST_FINISH = 2'd2
   } state_t;

   state_t                    state_r;
   logic [CNT_W-1:0]          cnt_r;
   logic [CNT_W-1:0]          cnt_nxt_s;
   logic signed [DATA_W-1:0]  in_sh_r [N_IN];
   logic signed [ACC_W-1:0]   acc_r [N_OUT];
   logic signed [PROD_W-1:0]  prod_s [N_OUT];

   // Add the bias (scaled to product precision), rescale with floor
   // semantics, then clamp to [0, 2^(DATA_W-1)-1].
   function automatic logic signed [DATA_W-1:0] relu_sat(
      input logic signed [ACC_W-1:0]  acc,
      input logic signed [DATA_W-1:0] b
   );
      logic [ACC_W:0]           bias_ext;
      logic signed [ACC_W:0]    sum;
      logic signed [ACC_W:0]    r;
      logic signed [DATA_W-1:0] res;
      bias_ext = {{(ACC_W + 1 - DATA_W){b[DATA_W-1]}}, b} << FRAC_W;
      sum      = $signed({acc[ACC_W-1], acc}) + $signed(bias_ext);
      r        = sum >>> FRAC_W;
      if (r[ACC_W]) begin
         res = '0;
      end else if (|r[ACC_W-1:DATA_W-1]) begin
         res = {1'b0, {(DATA_W - 1){1'b1}}};
      end else begin
         res = r[DATA_W-1:0];
      end
      return res;
   endfunction

   assign cnt_nxt_s = cnt_r + CNT_W'(1);

   // One product per output lane: current input element times its ROM weight.
   always_comb begin
      for (int j = 0; j < N_OUT; j++) begin
         prod_s[j] = PROD_W'(in_sh_r[0]) * PROD_W'($signed(w_data[j*DATA_W +: DATA_W]));
      end
   end

   // Control FSM, input shift register, accumulators and registered outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         cnt_r     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         w_addr    <= '0;
         for (int i = 0; i < N_IN; i++) begin
            in_sh_r[i] <= '0;
         end
         for (int j = 0; j < N_OUT; j++) begin
            acc_r[j]    <= '0;
            out_data[j] <= '0;
         end
      end else begin
         out_valid <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  in_sh_r  <= in_data;
                  cnt_r    <= '0;
                  w_addr   <= '0;
                  in_ready <= 1'b0;
                  for (int j = 0; j < N_OUT; j++) begin
                     acc_r[j] <= '0;
                  end
                  state_r  <= ST_ACC;
               end else begin
                  in_ready <= 1'b1;
               end
            end
            ST_ACC: begin
               // Cycle 0 only issues the first ROM read; from cycle 1 on,
               // the row requested one cycle earlier is on w_data.
               if (cnt_r != '0) begin
                  for (int j = 0; j < N_OUT; j++) begin
                     acc_r[j] <= acc_r[j] + ACC_W'(prod_s[j]);
                  end
                  for (int i = 0; i < N_IN - 1; i++) begin
                     in_sh_r[i] <= in_sh_r[i+1];
                  end
                  in_sh_r[N_IN-1] <= '0;
               end else begin
                  in_sh_r <= in_sh_r;
               end
               // Address holds at the last row once all rows are requested.
               if (cnt_r < CNT_ADDR_LAST) begin
                  w_addr <= cnt_nxt_s[AW-1:0];
               end else begin
                  w_addr <= w_addr;
               end
               if (cnt_r == CNT_LAST) begin
                  state_r <= ST_FINISH;
               end else begin
                  cnt_r <= cnt_nxt_s;
               end
            end
            ST_FINISH: begin
               for (int j = 0; j < N_OUT; j++) begin
                  out_data[j] <= relu_sat(acc_r[j], bias[j]);
               end
               out_valid <= 1'b1;
               in_ready  <= 1'b1;
               state_r   <= ST_IDLE;
            end
            default: begin
               in_ready <= 1'b1;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dense_mac_relu.sv
// Self-checking bench for dense_mac_relu: a reference model fills a
// scoreboard at each accepted vector; a monitor pops and compares results.
module tb_dense_mac_relu;

   localparam int DW    = 16;
   localparam int FW    = 10;
   localparam int N_IN  = 128;
   localparam int N_OUT = 16;
   localparam int LAT   = N_IN + 2;

   logic                   clk = 1'b0;
   logic                   reset = 1'b1;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic signed [DW-1:0]   in_data [N_IN];
   logic [$clog2(N_IN)-1:0] w_addr;
   logic [N_OUT*DW-1:0]    w_data;
   logic signed [DW-1:0]   bias [N_OUT];
   logic                   out_valid;
   logic signed [DW-1:0]   out_data [N_OUT];

   logic signed [DW-1:0]   w_mem [N_IN][N_OUT];

   typedef struct {
      logic [N_OUT*DW-1:0] v;
      int                  c;
   } exp_t;

   exp_t exp_q[$];
   exp_t e_push;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   logic prev_ov = 1'b0;

   dense_mac_relu #(.DATA_W(DW), .FRAC_W(FW), .N_IN(N_IN), .N_OUT(N_OUT)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .w_addr(w_addr), .w_data(w_data), .bias(bias),
      .out_valid(out_valid), .out_data(out_data)
   );

   always #5 clk = ~clk;

   // Synchronous weight ROM model: row w_addr appears one cycle later.
   always @(posedge clk) begin
      for (int j = 0; j < N_OUT; j++) w_data[j*DW +: DW] <= w_mem[w_addr][j];
   end

   function automatic logic [N_OUT*DW-1:0] model();
      logic [N_OUT*DW-1:0] res;
      longint s;
      longint r;
      for (int j = 0; j < N_OUT; j++) begin
         s = 0;
         for (int k = 0; k < N_IN; k++) s += longint'(in_data[k]) * longint'(w_mem[k][j]);
         s += longint'(bias[j]) * 1024;
         r = s >>> FW;
         if (r < 0) r = 0;
         else if (r > 32767) r = 32767;
         res[j*DW +: DW] = 16'(r);
      end
      return res;
   endfunction

   // Scoreboard push at every accepted vector; reset discards pending jobs.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (reset) begin
         exp_q.delete();
      end else if (in_valid && in_ready) begin
         e_push.v = model();
         e_push.c = cyc;
         exp_q.push_back(e_push);
      end
   end

   // Result monitor: pop, compare data, latency and pulse width.
   always @(negedge clk) begin
      logic [N_OUT*DW-1:0] got;
      exp_t e;
      for (int j = 0; j < N_OUT; j++) got[j*DW +: DW] = out_data[j];
      if (out_valid) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_out_valid: got out_valid=1 at cycle %0d, required no result", cyc);
         end else begin
            e = exp_q.pop_front();
            if (got !== e.v) begin
               errors++;
               $display("FAIL result_data: got %h required %h", got, e.v);
            end
            checks++;
            if (cyc - e.c - 1 !== LAT) begin
               errors++;
               $display("FAIL latency: got %0d required %0d", cyc - e.c - 1, LAT);
            end
         end
         checks++;
         if (prev_ov) begin
            errors++;
            $display("FAIL pulse_width: out_valid high 2 cycles in a row, required 1");
         end
      end
      prev_ov = out_valid;
   end

   task automatic set_uniform(input int in_v, input int w0, input int w_rest, input int b3);
      for (int k = 0; k < N_IN; k++) begin
         in_data[k] = 16'(in_v);
         for (int j = 0; j < N_OUT; j++) w_mem[k][j] = (j == 0) ? 16'(w0) : 16'(w_rest);
      end
      for (int j = 0; j < N_OUT; j++) bias[j] = (j == 3) ? 16'(b3) : 16'sd0;
   endtask

   task automatic send_vector();
      int t;
      @(negedge clk);
      t = 0;
      while (!in_ready && t < 400) begin
         @(negedge clk);
         t++;
      end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (exp_q.size() != 0 && t < 400) begin
         @(negedge clk);
         t++;
      end
      @(negedge clk);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || w_addr !== '0) begin
         errors++;
         $display("FAIL reset_ctrl: got out_valid=%b in_ready=%b w_addr=%0d, required 0 1 0",
                  out_valid, in_ready, w_addr);
      end
      for (int j = 0; j < N_OUT; j++) begin
         checks++;
         if (out_data[j] !== 16'sd0) begin
            errors++;
            $display("FAIL reset_out_data[%0d]: got %0d required 0", j, out_data[j]);
         end
      end
   endtask

   task automatic test_basic();
      set_uniform(128, 1024, 0, 0);
      send_vector();
      wait_drain();
      checks++;
      if (out_data[0] !== 16'sd16384 || out_data[1] !== 16'sd0) begin
         errors++;
         $display("FAIL basic: got out0=%0d out1=%0d required 16384 0", out_data[0], out_data[1]);
      end
   endtask

   task automatic test_relu_bias();
      set_uniform(128, -1024, 0, 0);
      send_vector();
      wait_drain();
      checks++;
      if (out_data[0] !== 16'sd0) begin
         errors++;
         $display("FAIL relu_neg: got %0d required 0", out_data[0]);
      end
      set_uniform(128, 0, 0, 512);
      send_vector();
      wait_drain();
      checks++;
      if (out_data[3] !== 16'sd512 || out_data[0] !== 16'sd0) begin
         errors++;
         $display("FAIL bias: got out3=%0d out0=%0d required 512 0", out_data[3], out_data[0]);
      end
   endtask

   task automatic test_saturation();
      set_uniform(1024, 1024, 1024, 0);
      send_vector();
      wait_drain();
      for (int j = 0; j < N_OUT; j++) begin
         checks++;
         if (out_data[j] !== 16'sd32767) begin
            errors++;
            $display("FAIL saturation[%0d]: got %0d required 32767", j, out_data[j]);
         end
      end
   endtask

   task automatic test_back_to_back();
      int t;
      set_uniform(128, 1024, 0, 0);
      send_vector();
      repeat (39) @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_ready: got in_ready=%b required 0", in_ready);
      end
      for (int k = 0; k < N_IN; k++) in_data[k] = 16'sd500;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      for (int k = 0; k < N_IN; k++) in_data[k] = 16'sd64;
      t = 0;
      while (!out_valid && t < 300) begin
         @(negedge clk);
         t++;
      end
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_data[0] !== 16'sd16384) begin
         errors++;
         $display("FAIL ignored_pulse: got out_valid=%b in_ready=%b out0=%0d required 1 1 16384",
                  out_valid, in_ready, out_data[0]);
      end
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wait_drain();
      checks++;
      if (out_data[0] !== 16'sd8192) begin
         errors++;
         $display("FAIL back_to_back: got %0d required 8192", out_data[0]);
      end
   endtask

   task automatic test_reset_mid_job();
      int ov_cnt;
      set_uniform(1024, 1024, 1024, 0);
      send_vector();
      repeat (50) @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b1 || w_addr !== '0 || out_data[0] !== 16'sd0) begin
         errors++;
         $display("FAIL abort_state: got in_ready=%b w_addr=%0d out0=%0d required 1 0 0",
                  in_ready, w_addr, out_data[0]);
      end
      ov_cnt = 0;
      repeat (150) begin
         @(negedge clk);
         if (out_valid) ov_cnt++;
      end
      checks++;
      if (ov_cnt != 0) begin
         errors++;
         $display("FAIL abort_no_result: got %0d out_valid pulses required 0", ov_cnt);
      end
      set_uniform(128, 1024, 0, 0);
      send_vector();
      wait_drain();
      checks++;
      if (out_data[0] !== 16'sd16384) begin
         errors++;
         $display("FAIL after_abort: got %0d required 16384", out_data[0]);
      end
   endtask

   task automatic test_random();
      int tmp;
      for (int n = 0; n < 4; n++) begin
         for (int k = 0; k < N_IN; k++) begin
            tmp = int'($urandom_range(4095, 0)) - 2048;
            in_data[k] = tmp[15:0];
            for (int j = 0; j < N_OUT; j++) begin
               tmp = int'($urandom_range(4095, 0)) - 2048;
               w_mem[k][j] = tmp[15:0];
            end
         end
         for (int j = 0; j < N_OUT; j++) begin
            tmp = int'($urandom_range(8191, 0)) - 4096;
            bias[j] = tmp[15:0];
         end
         send_vector();
         wait_drain();
      end
   endtask

   initial begin
      set_uniform(0, 0, 0, 0);
      test_reset();
      test_basic();
      test_relu_bias();
      test_saturation();
      test_back_to_back();
      test_reset_mid_job();
      test_random();
      repeat (5) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
